// File: rtl/mem_stage_if.sv
// Execute->memory->writeback bus bundle for the memory-access stage.
// The master view belongs to mem_stage; the slave view to its environment.
interface mem_stage_if;
  logic         flush;
  logic         W_allowin;
  logic         M_allowin;
  logic         EM_valid;
  logic [194:0] EM_BUS;
  logic [31:0]  data_sram_rdata;
  logic         MW_valid;
  logic [190:0] MW_BUS;
  logic [36:0]  MD_for_BUS;

  modport master (
    input  flush, W_allowin, EM_valid, EM_BUS, data_sram_rdata,
    output M_allowin, MW_valid, MW_BUS, MD_for_BUS
  );

  modport slave (
    output flush, W_allowin, EM_valid, EM_BUS, data_sram_rdata,
    input  M_allowin, MW_valid, MW_BUS, MD_for_BUS
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: load alignment/extension, read-data hold
// during writeback stalls, exception/CSR pass-through and decode forwarding.
module mem_stage (
  input  logic        clk,
  input  logic        rstn,
  mem_stage_if.master bus
);
  logic         m_valid;
  logic         m_allowin;
  logic         mw_valid;
  logic         entry;
  logic [194:0] em_bus_r;
  logic [31:0]  rbuf;
  logic         rbuf_vld;

  logic [31:0] pc, rf_wdata, vaddr, csr_wmask, csr_wdata;
  logic        gr_we, ex, esubcode, csr_we, gr_we_out;
  logic [4:0]  dest;
  logic [3:0]  res_from_mem;
  logic [7:0]  ecode;
  logic [13:0] csr_addr;

  logic [31:0] rdata, ld_data, final_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign {pc, rf_wdata, gr_we, dest, res_from_mem, vaddr, ex, ecode, esubcode,
          csr_addr, csr_we, csr_wmask, csr_wdata} = em_bus_r;

  assign m_allowin = !m_valid || bus.W_allowin;
  assign mw_valid  = m_valid && !bus.flush;
  assign entry     = bus.EM_valid && m_allowin && !bus.flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid <= 1'b0;
    end else if (bus.flush) begin
      m_valid <= 1'b0;
    end else if (m_allowin) begin
      m_valid <= bus.EM_valid;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      em_bus_r <= '0;
    end else if (entry) begin
      em_bus_r <= bus.EM_BUS;
    end
  end

  // The SRAM only holds its read data for one cycle; keep the first-cycle
  // word whenever writeback does not take the instruction that cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rbuf     <= '0;
      rbuf_vld <= 1'b0;
    end else if (bus.flush || entry) begin
      rbuf_vld <= 1'b0;
    end else if (m_valid && !rbuf_vld && !(mw_valid && bus.W_allowin)) begin
      rbuf     <= bus.data_sram_rdata;
      rbuf_vld <= 1'b1;
    end
  end

  assign rdata = rbuf_vld ? rbuf : bus.data_sram_rdata;

  always_comb begin
    ld_byte = rdata[7:0];
    case (vaddr[1:0])
      2'd0: ld_byte = rdata[7:0];
      2'd1: ld_byte = rdata[15:8];
      2'd2: ld_byte = rdata[23:16];
      2'd3: ld_byte = rdata[31:24];
      default: ld_byte = rdata[7:0];
    endcase
    ld_half = vaddr[1] ? rdata[31:16] : rdata[15:0];

    if (res_from_mem[3]) begin
      ld_data = rdata;
    end else if (res_from_mem[1]) begin
      ld_data = {{16{ld_half[15] & ~res_from_mem[2]}}, ld_half};
    end else begin
      ld_data = {{24{ld_byte[7] & ~res_from_mem[2]}}, ld_byte};
    end

    final_wdata = (res_from_mem != 4'd0) ? ld_data : rf_wdata;
  end

  assign gr_we_out = gr_we && !ex;

  assign bus.M_allowin  = m_allowin;
  assign bus.MW_valid   = mw_valid;
  assign bus.MW_BUS     = {pc, final_wdata, gr_we_out, dest, ex, ecode, esubcode,
                           csr_addr, csr_we, csr_wmask, csr_wdata, vaddr};
  assign bus.MD_for_BUS = {dest & {5{m_valid && gr_we_out}}, final_wdata};
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed spec scenarios followed by random traffic,
// all checked against a transaction-level model of the stage.
module tb_mem_stage;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rf_wdata;
    logic        gr_we;
    logic [4:0]  dest;
    logic [3:0]  rfm;
    logic [31:0] vaddr;
    logic        ex;
    logic [7:0]  ecode;
    logic        esub;
    logic [13:0] csr_addr;
    logic        csr_we;
    logic [31:0] wmask;
    logic [31:0] wdata;
  } ins_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mem_stage_if bus ();
  mem_stage dut (.clk(clk), .rstn(rstn), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Model: the instruction sitting in M, and the word it latched if stalled.
  bit          m_vld;
  ins_t        m_ins;
  bit          held_vld;
  logic [31:0] held;

  function automatic logic [31:0] exp_final(ins_t i, logic [31:0] d);
    logic [31:0] s;
    int unsigned sh;
    if (i.rfm == 4'd0) return i.rf_wdata;
    if (i.rfm[3]) return d;
    if (i.rfm[1]) begin
      sh = i.vaddr[1] ? 16 : 0;
      s  = (d >> sh) & 32'h0000_FFFF;
      if (!i.rfm[2] && s[15]) s = s | 32'hFFFF_0000;
      return s;
    end
    sh = 8 * int'(i.vaddr[1:0]);
    s  = (d >> sh) & 32'h0000_00FF;
    if (!i.rfm[2] && s[7]) s = s | 32'hFFFF_FF00;
    return s;
  endfunction

  function automatic logic [190:0] exp_mw(ins_t i, logic [31:0] d);
    return {i.pc, exp_final(i, d), i.gr_we & ~i.ex, i.dest, i.ex, i.ecode,
            i.esub, i.csr_addr, i.csr_we, i.wmask, i.wdata, i.vaddr};
  endfunction

  function automatic ins_t mk(logic [31:0] rf, logic gw, logic [4:0] dst,
                              logic [3:0] rfm, logic [31:0] va, logic ex,
                              logic [7:0] ec);
    ins_t i;
    i.pc = 32'h1C00_0000 + rf; i.rf_wdata = rf; i.gr_we = gw; i.dest = dst;
    i.rfm = rfm; i.vaddr = va; i.ex = ex; i.ecode = ec; i.esub = ex;
    i.csr_addr = 14'h0005; i.csr_we = 1'b1; i.wmask = 32'h0000_FFFF;
    i.wdata = ~rf;
    return i;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t i;
    logic [3:0] rfm_tab [6];
    rfm_tab = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd8};
    i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    i.rfm = rfm_tab[$urandom_range(0, 5)];
    i.ex  = ($urandom_range(0, 7) == 0);
    return i;
  endfunction

  task automatic chk(input string tag, input logic [190:0] obs, input logic [190:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check current outputs against the model, then advance one clock.
  task automatic cycle();
    logic [31:0] d;
    d = held_vld ? held : bus.data_sram_rdata;
    chk("MW_valid", 191'(m_vld && !bus.flush), 191'(bus.MW_valid));
    chk("M_allowin", 191'(bus.M_allowin), 191'(!m_vld || bus.W_allowin));
    if (m_vld) begin
      chk("MW_BUS", bus.MW_BUS, exp_mw(m_ins, d));
      chk("MD_for_BUS", 191'(bus.MD_for_BUS),
          191'({m_ins.dest & {5{m_ins.gr_we & ~m_ins.ex}}, exp_final(m_ins, d)}));
    end else begin
      chk("MD_dest_idle", 191'(bus.MD_for_BUS[36:32]), 191'(5'd0));
    end
    @(posedge clk);
    if (bus.flush) begin
      m_vld = 1'b0; held_vld = 1'b0;
    end else if (!m_vld || bus.W_allowin) begin
      if (bus.EM_valid) m_ins = bus.EM_BUS;
      m_vld = bus.EM_valid; held_vld = 1'b0;
    end else if (!held_vld) begin
      held = d; held_vld = 1'b1;
    end
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    bus.flush = 1'b0; bus.W_allowin = 1'b0; bus.EM_valid = 1'b0;
    bus.EM_BUS = '0; bus.data_sram_rdata = 32'hA5A5_A5A5;
    m_vld = 1'b0; held_vld = 1'b0; m_ins = '0; held = '0;
    #2;
    chk("rst_MW_valid", 191'(bus.MW_valid), 191'(1'b0));
    chk("rst_M_allowin", 191'(bus.M_allowin), 191'(1'b1));
    chk("rst_MD", 191'(bus.MD_for_BUS), '0);
    chk("rst_MW_BUS", bus.MW_BUS, '0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Back-to-back ALU ops
    bus.W_allowin = 1'b1; bus.EM_valid = 1'b1;
    bus.EM_BUS = mk(32'h11, 1'b1, 5'd3, 4'd0, 32'h0, 1'b0, 8'h0);
    #3; cycle();
    bus.EM_BUS = mk(32'h22, 1'b0, 5'd7, 4'd0, 32'h0, 1'b0, 8'h0);
    #3;
    chk("alu1_wdata", 191'(bus.MW_BUS[158:127]), 191'(32'h11));
    chk("alu1_md_dest", 191'(bus.MD_for_BUS[36:32]), 191'(5'd3));
    cycle();
    bus.EM_BUS = mk(32'h0, 1'b1, 5'd4, 4'd1, 32'h3, 1'b0, 8'h0);
    #3;
    chk("alu2_wdata", 191'(bus.MW_BUS[158:127]), 191'(32'h22));
    chk("alu2_md_dest", 191'(bus.MD_for_BUS[36:32]), 191'(5'd0));
    cycle();

    // Loads on 0x80FF7F01
    bus.data_sram_rdata = 32'h80FF_7F01;
    bus.EM_BUS = mk(32'h0, 1'b1, 5'd4, 4'd5, 32'h3, 1'b0, 8'h0);
    #3;
    chk("ld_b_sext", 191'(bus.MW_BUS[158:127]), 191'(32'hFFFF_FF80));
    cycle();
    bus.EM_BUS = mk(32'h0, 1'b1, 5'd4, 4'd2, 32'h2, 1'b0, 8'h0);
    #3;
    chk("ld_bu_zext", 191'(bus.MW_BUS[158:127]), 191'(32'h0000_0080));
    cycle();
    bus.EM_BUS = mk(32'h0, 1'b1, 5'd6, 4'd8, 32'h100, 1'b0, 8'h0);
    #3;
    chk("ld_h_sext", 191'(bus.MW_BUS[158:127]), 191'(32'hFFFF_80FF));
    cycle();

    // Stall buffering: word load held for 3 cycles while rdata changes
    bus.EM_BUS = mk(32'h33, 1'b1, 5'd8, 4'd0, 32'h0, 1'b0, 8'h0);
    bus.data_sram_rdata = 32'hDEAD_BEEF; bus.W_allowin = 1'b0;
    #3;
    chk("stall_allowin", 191'(bus.M_allowin), 191'(1'b0));
    cycle();
    for (int unsigned k = 0; k < 2; k++) begin
      bus.data_sram_rdata = 32'h1234_5678;
      #3;
      chk("stall_allowin", 191'(bus.M_allowin), 191'(1'b0));
      chk("stall_hold", 191'(bus.MW_BUS[158:127]), 191'(32'hDEAD_BEEF));
      cycle();
    end
    bus.W_allowin = 1'b1;
    #3;
    chk("stall_release", 191'(bus.MW_BUS[158:127]), 191'(32'hDEAD_BEEF));
    cycle();

    // Exception pass-through
    bus.EM_BUS = mk(32'h44, 1'b1, 5'd5, 4'd0, 32'h0, 1'b1, 8'h09);
    #3; cycle();
    bus.EM_valid = 1'b0;
    #3;
    chk("exc_gr_we_out", 191'(bus.MW_BUS[126]), 191'(1'b0));
    chk("exc_md_dest", 191'(bus.MD_for_BUS[36:32]), 191'(5'd0));
    chk("exc_ecode", 191'(bus.MW_BUS[119:112]), 191'(8'h09));
    cycle();

    // Flush a stalled load while execute offers a new instruction
    bus.EM_valid = 1'b1;
    bus.EM_BUS = mk(32'h0, 1'b1, 5'd9, 4'd8, 32'h200, 1'b0, 8'h0);
    #3; cycle();
    bus.EM_valid = 1'b0; bus.W_allowin = 1'b0; bus.data_sram_rdata = 32'hCAFE_F00D;
    #3; cycle();
    bus.flush = 1'b1; bus.EM_valid = 1'b1;
    bus.EM_BUS = mk(32'h55, 1'b1, 5'd10, 4'd0, 32'h0, 1'b0, 8'h0);
    #3;
    chk("flush_mw_valid", 191'(bus.MW_valid), 191'(1'b0));
    cycle();
    bus.flush = 1'b0; bus.EM_valid = 1'b0; bus.W_allowin = 1'b1;
    #3;
    chk("flush_after_valid", 191'(bus.MW_valid), 191'(1'b0));
    chk("flush_rbuf_vld", 191'(dut.rbuf_vld), 191'(1'b0));
    cycle();

    // Random traffic
    for (int unsigned n = 0; n < 400; n++) begin
      bus.EM_valid        = $urandom_range(0, 1);
      bus.W_allowin       = ($urandom_range(0, 2) != 0);
      bus.flush           = ($urandom_range(0, 15) == 0);
      bus.EM_BUS          = rnd_ins();
      bus.data_sram_rdata = $urandom;
      #3; cycle();
    end

    // Async reset in the middle of a stall
    bus.flush = 1'b0; bus.W_allowin = 1'b1; bus.EM_valid = 1'b1;
    bus.EM_BUS = mk(32'h66, 1'b1, 5'd11, 4'd8, 32'h0, 1'b0, 8'h0);
    #3; cycle();
    bus.EM_valid = 1'b0; bus.W_allowin = 1'b0;
    #3;
    chk("pre_rst_valid", 191'(bus.MW_valid), 191'(1'b1));
    rstn = 1'b0;
    #1;
    chk("arst_mw_valid", 191'(bus.MW_valid), 191'(1'b0));
    chk("arst_allowin", 191'(bus.M_allowin), 191'(1'b1));
    chk("arst_md", 191'(bus.MD_for_BUS), '0);
    m_vld = 1'b0; held_vld = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    #3; cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
